// File: rtl/pixel_asm_pkg.sv
// Shared types and constants for the pixel packet assembler.
//   state_t    : assembler FSM states
//   err_code_t : sticky error code reported on err_code
//   DEFAULT_SYNC_BYTE : start-of-frame marker used when no override is given
package pixel_asm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CAM     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_CSUM    = 2'b10
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/stall_timeout_timer.sv
// Counts consecutive stalled cycles and pulses 'expired' on the TIMEOUT_CYCLES-th one.
// Ports:
//   clk     in  : system clock
//   reset   in  : synchronous active-high reset
//   enable  in  : count this cycle (stalled while mid-frame)
//   clear   in  : restart the count (progress made, or not mid-frame); wins over enable
//   expired out : one-cycle pulse on the cycle the limit is reached
// TIMEOUT_CYCLES = 0 removes the counter and holds 'expired' low.
module stall_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, enable, clear};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          at_limit;

            // cnt_q holds the number of stalled cycles already seen, so the
            // current stalled cycle is the last allowed one when it equals limit-1.
            assign at_limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
            assign expired  = enable && !clear && at_limit;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable) begin
                    cnt_d = at_limit ? '0 : cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pixel_packet_assembler.sv
// Pops bytes from a first-word-fall-through UART RX FIFO, hunts for the sync byte,
// packs CHANNELS bytes per pixel, counts TOTAL_PIXELS pixels, optionally checks an
// XOR trailer and aborts frames that stall for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, reset     in  : clock, synchronous active-high reset
//   empty          in  : FIFO empty
//   pop_data       in  : FIFO head, valid while empty=0
//   pop            out : consume FIFO head at this edge (combinational)
//   cam_mode       in  : 1 = camera handshake only, sampled with the sync byte
//   pixel_data     out : assembled pixel, channel 0 in the MSBs
//   pixel_valid    out : one-cycle pulse with pixel_data/pixel_idx
//   pixel_idx      out : 0-based index of the pixel on pixel_data
//   frame_done     out : one-cycle pulse, good frame end
//   frame_err      out : one-cycle pulse, aborted frame
//   err_code       out : 00 none, 01 timeout, 10 checksum; sticky until next sync
//   sync_drop_cnt  out : saturating count of bytes discarded while hunting
module pixel_packet_assembler
    import pixel_asm_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH      = 8,
    parameter int unsigned            CHANNELS        = 3,
    parameter int unsigned            TOTAL_PIXELS    = 9600,
    parameter int unsigned            PIXEL_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  SYNC_BYTE       = DATA_WIDTH'(DEFAULT_SYNC_BYTE),
    parameter bit                     CHECKSUM_EN     = 1'b1,
    parameter int unsigned            TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          empty,
    input  logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          pop,
    input  logic                          cam_mode,
    output logic [CHANNELS*DATA_WIDTH-1:0] pixel_data,
    output logic                          pixel_valid,
    output logic [PIXEL_CNT_WIDTH-1:0]    pixel_idx,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic [1:0]                    err_code,
    output logic [7:0]                    sync_drop_cnt
);

    localparam int unsigned PW     = CHANNELS * DATA_WIDTH;
    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CHAN_W-1:0]          LAST_CHAN = CHAN_W'(CHANNELS - 1);
    localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_PIX  = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

    state_t                     state_q, state_d;
    logic [CHAN_W-1:0]          chan_q, chan_d;
    logic [PIXEL_CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [DATA_WIDTH-1:0]      csum_q, csum_d;
    logic [PW-1:0]              shift_q, shift_d;
    logic [PW-1:0]              pixel_data_q, pixel_data_d;
    logic [PIXEL_CNT_WIDTH-1:0] pixel_idx_q, pixel_idx_d;
    logic                       pixel_valid_q, pixel_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic                       frame_err_q, frame_err_d;
    err_code_t                  err_q, err_d;
    logic [7:0]                 drop_q, drop_d;

    logic pop_raw;
    logic in_frame;
    logic expired;

    assign in_frame = (state_q == PAYLOAD) || (state_q == CHECK);
    // Held low in reset so a reset mid-frame never drains the FIFO.
    assign pop      = pop_raw && !reset;

    stall_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (in_frame && empty),
        .clear   (pop_raw || !in_frame),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        pix_cnt_d     = pix_cnt_q;
        csum_d        = csum_q;
        shift_d       = shift_q;
        pixel_data_d  = pixel_data_q;
        pixel_idx_d   = pixel_idx_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        err_d         = err_q;
        drop_d        = drop_q;
        pop_raw       = 1'b0;

        unique case (state_q)
            HUNT: begin
                pop_raw = !empty;
                if (!empty) begin
                    if (pop_data == SYNC_BYTE) begin
                        err_d     = ERR_NONE;
                        chan_d    = '0;
                        pix_cnt_d = '0;
                        csum_d    = '0;
                        state_d   = cam_mode ? CAM : PAYLOAD;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end

            CAM: begin
                frame_done_d = 1'b1;
                state_d      = HUNT;
            end

            PAYLOAD: begin
                pop_raw = !empty;
                if (!empty) begin
                    shift_d = (shift_q << DATA_WIDTH) | PW'(pop_data);
                    csum_d  = csum_q ^ pop_data;
                    if (chan_q == LAST_CHAN) begin
                        chan_d        = '0;
                        pixel_data_d  = shift_d;
                        pixel_idx_d   = pix_cnt_q;
                        pixel_valid_d = 1'b1;
                        if (pix_cnt_q == LAST_PIX) begin
                            if (CHECKSUM_EN) begin
                                state_d = CHECK;
                            end else begin
                                state_d      = HUNT;
                                frame_done_d = 1'b1;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIXEL_CNT_WIDTH'(1);
                        end
                    end else begin
                        chan_d = chan_q + CHAN_W'(1);
                    end
                end else if (expired) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                    err_d       = ERR_TIMEOUT;
                end
            end

            CHECK: begin
                pop_raw = !empty;
                if (!empty) begin
                    state_d = HUNT;
                    if (pop_data == csum_q) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_CSUM;
                    end
                end else if (expired) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                    err_d       = ERR_TIMEOUT;
                end
            end

            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            chan_q        <= '0;
            pix_cnt_q     <= '0;
            csum_q        <= '0;
            shift_q       <= '0;
            pixel_data_q  <= '0;
            pixel_idx_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_q         <= ERR_NONE;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            pix_cnt_q     <= pix_cnt_d;
            csum_q        <= csum_d;
            shift_q       <= shift_d;
            pixel_data_q  <= pixel_data_d;
            pixel_idx_q   <= pixel_idx_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            err_q         <= err_d;
            drop_q        <= drop_d;
        end
    end

    assign pixel_data    = pixel_data_q;
    assign pixel_idx     = pixel_idx_q;
    assign pixel_valid   = pixel_valid_q;
    assign frame_done    = frame_done_q;
    assign frame_err     = frame_err_q;
    assign err_code      = err_q;
    assign sync_drop_cnt = drop_q;

endmodule

// File: tb/tb_pixel_packet_assembler.sv
// Scoreboard bench: stimulus pushes FIFO bytes plus expected pixel / frame-end
// events into queues; a negedge monitor pops and compares whenever the DUT pulses.
module tb_pixel_packet_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        empty;
    logic [7:0]  pop_data;
    logic        pop;
    logic        cam_mode;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] pixel_idx;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  sync_drop_cnt;

    always #5 clk = ~clk;

    pixel_packet_assembler #(
        .DATA_WIDTH      (8),
        .CHANNELS        (3),
        .TOTAL_PIXELS    (4),
        .PIXEL_CNT_WIDTH (16),
        .SYNC_BYTE       (8'hAA),
        .CHECKSUM_EN     (1'b1),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .empty         (empty),
        .pop_data      (pop_data),
        .pop           (pop),
        .cam_mode      (cam_mode),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .pixel_idx     (pixel_idx),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .sync_drop_cnt (sync_drop_cnt)
    );

    typedef struct {
        logic [23:0] data;
        logic [15:0] idx;
    } pix_exp_t;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
    } end_exp_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] fifo[$];
    bit         stall    = 1'b0;
    pix_exp_t   exp_pix[$];
    end_exp_t   exp_end[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        empty    = stall || (fifo.size() == 0);
        pop_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: pop is sampled mid-cycle, the model FIFO consumes on the edge,
    // and new head/empty are driven 1 time unit later.
    task automatic cycle();
        logic ps;
        @(negedge clk);
        ps = pop;
        @(posedge clk);
        if (ps && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        refresh();
    endtask

    task automatic sync_post();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pixel(input logic [23:0] d, input logic [15:0] i);
        pix_exp_t pe;
        pe.data = d;
        pe.idx  = i;
        exp_pix.push_back(pe);
    endtask

    task automatic expect_end(input bit is_err, input logic [1:0] code);
        end_exp_t ee;
        ee.is_err = is_err;
        ee.code   = code;
        exp_end.push_back(ee);
    endtask

    // Sync byte, 12 payload bytes first..first+11, trailer. Caller supplies the
    // hand-computed trailer and whether it is expected to be rejected.
    task automatic push_frame(input logic [7:0] first, input logic [7:0] trailer,
                              input bit bad);
        logic [7:0]  b;
        logic [23:0] d;
        fifo.push_back(8'hAA);
        for (int p = 0; p < 4; p++) begin
            d = '0;
            for (int c = 0; c < 3; c++) begin
                b = first + 8'(p * 3 + c);
                fifo.push_back(b);
                d = {d[15:0], b};
            end
            expect_pixel(d, 16'(p));
        end
        fifo.push_back(trailer);
        expect_end(bad, bad ? 2'b10 : 2'b00);
        refresh();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (fifo.size() > 0 && n < max) begin
            cycle();
            n++;
        end
        check("fifo_drained", fifo.size(), 0);
        repeat (4) cycle();
    endtask

    // Monitor
    pix_exp_t mp;
    end_exp_t me;
    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_valid) begin
                if (exp_pix.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got data 0x%0h idx %0d, required no pulse",
                             pixel_data, pixel_idx);
                end else begin
                    mp = exp_pix.pop_front();
                    check("pixel_data", pixel_data, mp.data);
                    check("pixel_idx", pixel_idx, mp.idx);
                end
            end
            if (frame_done || frame_err) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_end: got done=%0b err=%0b, required no pulse",
                             frame_done, frame_err);
                end else begin
                    me = exp_end.pop_front();
                    check("frame_err", frame_err, me.is_err);
                    check("frame_done", frame_done, !me.is_err);
                    check("err_code_at_end", err_code, me.code);
                end
            end
        end
    end

    initial begin
        int n;
        reset    = 1'b1;
        cam_mode = 1'b0;
        refresh();
        repeat (3) cycle();

        // Reset state
        @(negedge clk);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_data", pixel_data, 0);
        check("rst_pixel_idx", pixel_idx, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_sync_drop", sync_drop_cnt, 0);
        check("rst_pop", pop, 0);
        sync_post();
        reset = 1'b0;

        // Good frame: XOR of 01..0C is 0C
        push_frame(8'h01, 8'h0C, 1'b0);
        drain(100);
        check("good_err_code", err_code, 2'b00);

        // Bad checksum, then a good frame clears the sticky code
        push_frame(8'h01, 8'h00, 1'b1);
        drain(100);
        check("csum_err_sticky", err_code, 2'b10);
        push_frame(8'h10, 8'h00, 1'b0);  // XOR of 10..1B is 00
        drain(100);
        check("err_cleared", err_code, 2'b00);

        // Hunt: two junk bytes before the sync byte
        fifo.push_back(8'h55);
        fifo.push_back(8'h00);
        push_frame(8'h21, 8'h0C, 1'b0);  // XOR of 21..2C is 0C
        drain(100);
        check("hunt_drop_cnt", sync_drop_cnt, 8'd2);

        // Timeout: stall after 5 payload bytes
        fifo.push_back(8'hAA);
        for (int i = 1; i <= 5; i++) fifo.push_back(8'(i));
        expect_pixel(24'h010203, 16'd0);
        expect_end(1'b1, 2'b01);
        refresh();
        n = 0;
        while (fifo.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_err) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("timeout_latency", n, 16);
        check("timeout_err_code", err_code, 2'b01);
        sync_post();
        push_frame(8'h01, 8'h0C, 1'b0);
        drain(100);
        check("after_timeout_err_code", err_code, 2'b00);

        // Camera mode: frame_done two cycles after the sync pop
        cam_mode = 1'b1;
        fifo.push_back(8'hAA);
        expect_end(1'b0, 2'b00);
        refresh();
        cycle();
        cam_mode = 1'b0;
        @(negedge clk);
        check("cam_done_early", frame_done, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cam_done_2cyc", frame_done, 1);
        sync_post();
        fifo.push_back(8'h55);
        refresh();
        drain(20);
        check("cam_then_hunt_drop", sync_drop_cnt, 8'd3);

        // Reset mid-frame after pixel 1
        fifo.push_back(8'hAA);
        for (int i = 1; i <= 7; i++) fifo.push_back(8'(i));
        expect_pixel(24'h010203, 16'd0);
        expect_pixel(24'h040506, 16'd1);
        refresh();
        drain(100);
        fifo.push_back(8'h08);
        fifo.push_back(8'h09);
        fifo.push_back(8'h0A);
        refresh();
        reset = 1'b1;
        @(negedge clk);
        check("pop_in_reset", pop, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_pixel_data", pixel_data, 0);
        check("mid_rst_pixel_idx", pixel_idx, 0);
        check("mid_rst_pixel_valid", pixel_valid, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_sync_drop", sync_drop_cnt, 0);
        check("mid_rst_fifo_kept", fifo.size(), 3);
        sync_post();
        reset = 1'b0;
        push_frame(8'h10, 8'h00, 1'b0);
        drain(100);
        check("post_rst_drop_cnt", sync_drop_cnt, 8'd3);
        check("post_rst_err_code", err_code, 2'b00);

        repeat (5) cycle();
        check("pix_queue_empty", exp_pix.size(), 0);
        check("end_queue_empty", exp_end.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_packet_assembler.md
# pixel_packet_assembler

Parametrised successor to the UART pixel-assembly FSM. It pops bytes from the UART RX FIFO, hunts for a sync byte, groups `CHANNELS` bytes into one pixel word and counts pixels to `TOTAL_PIXELS`. It also checks an optional XOR checksum trailer and aborts stalled frames on timeout. It sits between the UART RX FIFO and the frame-buffer writer; in camera mode it only reports the sync handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width of the FIFO data.
- `CHANNELS`, 3: bytes per pixel, 1..4; channel 0 is received first.
- `TOTAL_PIXELS`, 9600: pixels per frame, at least 1.
- `PIXEL_CNT_WIDTH`, 16: width of `pixel_idx`; must hold `TOTAL_PIXELS-1`.
- `SYNC_BYTE`, 8'hAA: start-of-frame marker.
- `CHECKSUM_EN`, 1: 1 means a trailer byte follows the payload.
- `TIMEOUT_CYCLES`, 1_000_000: maximum consecutive empty cycles allowed mid-frame; 0 disables the timeout.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `empty` in 1: FIFO empty.
- `pop_data` in `DATA_WIDTH`: FIFO head. The FIFO is first-word-fall-through, so this is valid whenever `empty`=0.
- `pop` out 1: combinational; `pop`=`~empty` in every consuming state. The byte is consumed at the edge.
- `cam_mode` in 1: 1 selects camera, 0 selects UART. Sampled only when the sync byte is accepted.
- `pixel_data` out `CHANNELS*DATA_WIDTH`: assembled pixel, channel 0 in the MSBs.
- `pixel_valid` out 1: one-cycle pulse.
- `pixel_idx` out `PIXEL_CNT_WIDTH`: 0-based index of the pixel shown on `pixel_data`.
- `frame_done` out 1: one-cycle pulse marking a good frame end.
- `frame_err` out 1: one-cycle pulse marking an aborted frame.
- `err_code` out 2: 00 none, 01 timeout, 10 checksum. Sticky until the next accepted sync byte.
- `sync_drop_cnt` out 8: saturating count of bytes discarded while hunting.

## Operation
States:
- **HUNT**
  - Pops every available byte.
  - A byte equal to `SYNC_BYTE` is accepted: `err_code` is cleared and the channel count, pixel count and checksum are zeroed.
    - `cam_mode`=1 → CAM.
    - `cam_mode`=0 → PAYLOAD.
  - Any other byte → `sync_drop_cnt`+1 (saturates at 255).
- **CAM**: pulses `frame_done`, then → HUNT. No bytes are popped.
- **PAYLOAD**
  - On each pop, the byte is shifted into the channel register and XORed into the checksum.
  - On the byte with channel index `CHANNELS-1`, the pixel is complete:
    - `pixel_data` and `pixel_idx` are updated and `pixel_valid` pulses.
    - The pixel count increments.
    - If this was pixel `TOTAL_PIXELS-1`: → CHECK if `CHECKSUM_EN`, else → HUNT with a `frame_done` pulse.
- **CHECK**
  - Pops one byte.
  - If it equals the accumulated XOR: `frame_done` pulses.
  - Otherwise: `frame_err` pulses with `err_code`=10.
  - → HUNT either way.
- **Timeout** (PAYLOAD and CHECK only)
  - A counter increments on each cycle with `empty`=1 and clears on each pop.
  - When it reaches `TIMEOUT_CYCLES` (nonzero): `frame_err` pulses, `err_code`=01, → HUNT.
  - Partial pixel data is not emitted.
- `cam_mode` changes mid-frame are ignored.
- The sync byte is not included in the checksum.

## Timing
- Reset values: state HUNT; all outputs, counters, `pixel_data` and `err_code` are 0. `pop`=0 during reset.
- Throughput: one byte per cycle when the FIFO is never empty. A 3-channel pixel therefore takes 3 cycles, and the next pixel's first byte may be popped in the same cycle that `pixel_valid` is high.
- `pixel_valid`, `pixel_data` and `pixel_idx` are registered. They appear in the cycle after the edge that consumed the last channel byte.
- `frame_done` / `frame_err` are registered and appear in the cycle after the terminating pop or timeout.
  - With `CHECKSUM_EN`=0, `frame_done` coincides with the last `pixel_valid`.
- `pop` depends only on the current state and `empty`; it has no combinational path from `pop_data`.
- Reset mid-frame: the frame is abandoned without any `frame_err` pulse, and the FIFO contents are untouched.
- `TOTAL_PIXELS`=1 and `CHANNELS`=1 must work.
- `pixel_idx` never wraps: it stops at `TOTAL_PIXELS-1`.

## Structure
- Package `pixel_asm_pkg` holds:
  - the `state_t` enum (HUNT, CAM, PAYLOAD, CHECK);
  - the `err_code_t` enum (ERR_NONE, ERR_TIMEOUT, ERR_CSUM);
  - the default `SYNC_BYTE` constant.
- One sub-module, `stall_timeout_timer`, built from the `TIMEOUT_CYCLES` parameter:
  - inputs: `enable`, `clear`;
  - output: `expired` pulse;
  - counter width is `$clog2(TIMEOUT_CYCLES+1)`;
  - the instance is tied off when `TIMEOUT_CYCLES`=0.

## Test plan
- **Good frame:** `CHANNELS`=3, `TOTAL_PIXELS`=4, continuous stream AA, 12 bytes 0x01..0x0C, 0x0C → four `pixel_valid` pulses, data 0x010203, 0x040506, 0x070809, 0x0A0B0C with idx 0..3. `frame_done` pulses once, `err_code`=00.
- **Bad checksum:** same frame with trailer 0x00 → `frame_err` pulses once, `err_code`=10. A following good frame clears `err_code` at its AA.
- **Hunt:** bytes 55, 00, AA, then a valid frame → `sync_drop_cnt`=2 and the frame is accepted.
- **Timeout:** `TIMEOUT_CYCLES`=16; the stream stalls after 5 payload bytes → `frame_err` is seen 16 empty cycles later, `err_code`=01, 1 `pixel_valid`. The next AA restarts the frame.
- **Camera mode:** `cam_mode`=1, byte AA → `frame_done` appears 2 cycles after the pop. Subsequent bytes are treated as hunt bytes.
- **Reset mid-frame:** reset after pixel 1 → all outputs are 0 the next cycle, no pulses, and a fresh frame then completes normally.
